// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator control sequencer: opcodes, FSM states,
// instruction field positions and the decoded control word.
// Latency: n/a (definitions only). Backpressure: n/a.
package acc_ctrl_pkg;

    // Instruction word layout: [7:4] opcode, [3:0] operand
    localparam int INSTR_W = 8;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPD_MSB = 3;
    localparam int OPD_LSB = 0;
    localparam int OPD_W   = 4;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ADDR  = 4'h2;
    localparam logic [3:0] OP_ADDAU = 4'h3;
    localparam logic [3:0] OP_STA   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // PAUSE is only reachable when single-step support is compiled in
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // reg_addr carries the full operand; the top trims it to its register-file width
    typedef struct packed {
        logic       load_acc;
        logic       sel_acc1;
        logic       sel_acc0;
        logic [3:0] a_imm;
        logic [2:0] au_op;
        logic [3:0] reg_addr;
        logic       reg_we;
        logic       is_jmp;
        logic       is_jz;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OPD_W-1:0] operand_of(input logic [INSTR_W-1:0] ir);
        return ir[OPD_MSB:OPD_LSB];
    endfunction

endpackage

// File: rtl/acc_instr_decoder.sv
// Instruction decoder: maps the instruction register onto the control word.
// Latency: purely combinational. Backpressure: none.
// Ports: ir (instruction register) in, ctrl (decoded control word) out.
module acc_instr_decoder
    import acc_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output ctrl_t              ctrl
);

    logic [3:0]       opcode;
    logic [OPD_W-1:0] operand;

    assign opcode  = opcode_of(ir);
    assign operand = operand_of(ir);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_NOP: ;
            OP_ADDI: begin
                ctrl.load_acc = 1'b1;
                ctrl.a_imm    = operand;
            end
            OP_ADDR: begin
                ctrl.load_acc = 1'b1;
                ctrl.sel_acc0 = 1'b1;
                ctrl.reg_addr = operand;
            end
            OP_ADDAU: begin
                ctrl.load_acc = 1'b1;
                ctrl.sel_acc1 = 1'b1;
                ctrl.au_op    = operand[2:0];
            end
            OP_STA: begin
                ctrl.reg_we   = 1'b1;
                ctrl.reg_addr = operand;
            end
            OP_JMP:  ctrl.is_jmp  = 1'b1;
            OP_JZ:   ctrl.is_jz   = 1'b1;
            OP_HALT: ctrl.is_halt = 1'b1;
            // 7..E have no defined meaning: behave as NOP but flag it
            default: ctrl.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/acc_ctrl_sequencer.sv
// Control sequencer for the 8-bit accumulator datapath: fetch over req/ack, decode, one-cycle control pulses.
// Latency: 2 cycles per instruction with zero-wait ack (FETCH + EXEC); control pulses last exactly the EXEC cycle.
// Backpressure: ImemReq/ImemAddr held stable until ImemAck; FETCH waits indefinitely.
// Ports: CLK/CLB clock and async active-low reset; Start run pulse; ImemReq/ImemAddr/ImemAck/ImemData fetch
// interface; AccZero accumulator-zero status; LoadAcc/SelAcc1/SelAcc0/A_Imm/AuOp/RegAddr/RegWe control pulses;
// Busy/Halted/Illegal status. Optional macro ACC_SEQ_STEP_EN adds input Step and a PAUSE state after each EXEC.
module acc_ctrl_sequencer
    import acc_ctrl_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int REG_AW = 2
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              Start,
    output logic              ImemReq,
    output logic [PC_W-1:0]   ImemAddr,
    input  logic              ImemAck,
    input  logic [7:0]        ImemData,
    input  logic              AccZero,
    output logic              LoadAcc,
    output logic              SelAcc1,
    output logic              SelAcc0,
    output logic [3:0]        A_Imm,
    output logic [2:0]        AuOp,
    output logic [REG_AW-1:0] RegAddr,
    output logic              RegWe,
    output logic              Busy,
    output logic              Halted,
    output logic              Illegal
`ifdef ACC_SEQ_STEP_EN
    ,
    input  logic              Step
`endif
);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [INSTR_W-1:0] ir;
    logic              illegal_q;
    ctrl_t             cw;
    logic              exec;
    logic              take_jump;

    acc_instr_decoder u_dec (
        .ir   (ir),
        .ctrl (cw)
    );

    assign exec      = (state == ST_EXEC);
    // AccZero already reflects the previous LoadAcc by the time this EXEC cycle is reached
    assign take_jump = cw.is_jmp | (cw.is_jz & AccZero);
    assign pc_nxt    = take_jump ? PC_W'(operand_of(ir)) : pc + PC_W'(1);

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: if (Start) state_nxt = ST_FETCH;
            ST_FETCH:         if (ImemAck) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (cw.is_halt) begin
                    state_nxt = ST_HALT;
                end else begin
`ifdef ACC_SEQ_STEP_EN
                    state_nxt = ST_PAUSE;
`else
                    state_nxt = ST_FETCH;
`endif
                end
            end
`ifdef ACC_SEQ_STEP_EN
            ST_PAUSE:         if (Step) state_nxt = ST_FETCH;
`endif
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: if (Start) pc <= '0;
                ST_FETCH:         if (ImemAck) ir <= ImemData;
                ST_EXEC: begin
                    pc <= pc_nxt;
                    if (cw.is_illegal) illegal_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Everything below depends only on state and IR/PC registers: no input-to-output paths
    always_comb begin
        ImemReq  = (state == ST_FETCH);
        ImemAddr = pc;
        Busy     = (state == ST_FETCH) || (state == ST_EXEC);
        Halted   = (state == ST_HALT);
        Illegal  = illegal_q;
        LoadAcc  = 1'b0;
        SelAcc1  = 1'b0;
        SelAcc0  = 1'b0;
        A_Imm    = '0;
        AuOp     = '0;
        RegAddr  = '0;
        RegWe    = 1'b0;
        if (exec) begin
            LoadAcc = cw.load_acc;
            SelAcc1 = cw.sel_acc1;
            SelAcc0 = cw.sel_acc0;
            A_Imm   = cw.a_imm;
            AuOp    = cw.au_op;
            RegAddr = REG_AW'(cw.reg_addr);
            RegWe   = cw.reg_we;
        end
    end

endmodule

// File: doc/acc_ctrl_sequencer.md
Name: acc_ctrl_sequencer

Overview:
- Control sequencer that drives the 8-bit accumulator datapath.
- Fetches 8-bit instructions from instruction memory over a req/ack handshake, decodes them, and issues one-cycle control pulses: LoadAcc/SelAcc1/SelAcc0, the 4-bit immediate, the AU op, and register-file write-back.
- Sits between instruction memory and the accumulator, register file and AU.

Parameters:
- PC_W, 8: program counter / ImemAddr width.
- REG_AW, 2: register-file address width.

Ports:
- CLK  in  1  clock, rising edge.
- CLB  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse that begins execution at PC=0.
- ImemReq  out  1  fetch request.
- ImemAddr  out  PC_W  fetch address, equals PC.
- ImemAck  in  1  fetch acknowledge; ImemData valid in the same cycle.
- ImemData  in  8  instruction word.
- AccZero  in  1  high when AccOut == 0 (computed outside).
- LoadAcc  out  1  accumulate enable pulse.
- SelAcc1  out  1  0 = immediate/register path, 1 = AU output.
- SelAcc0  out  1  0 = A_Imm, 1 = B_RegOut.
- A_Imm  out  4  immediate operand.
- AuOp  out  3  AU operation select.
- RegAddr  out  REG_AW  register-file address (read and write).
- RegWe  out  1  register write pulse; data written is AccOut.
- Busy  out  1  high in FETCH or EXEC.
- Halted  out  1  high in HALT.
- Illegal  out  1  sticky flag: undefined opcode was executed.

Behaviour:
- Instruction format: [7:4] opcode, [3:0] operand.
- Opcodes:
  - 0 NOP.
  - 1 ADDI: LoadAcc=1, SelAcc1=0, SelAcc0=0, A_Imm=op[3:0].
  - 2 ADDR: LoadAcc=1, SelAcc1=0, SelAcc0=1, RegAddr=op[REG_AW-1:0].
  - 3 ADDAU: LoadAcc=1, SelAcc1=1, AuOp=op[2:0].
  - 4 STA: RegWe=1, RegAddr=op[REG_AW-1:0].
  - 5 JMP: PC <= zero-extended op[3:0].
  - 6 JZ: if AccZero, PC <= zero-extended op[3:0], else PC+1.
  - F HALT.
  - 7..E: executed as NOP and set Illegal.
- States: IDLE, FETCH, EXEC, HALT (encoding lives in the package).
- IDLE -> FETCH on Start.
- FETCH:
  - ImemReq=1, ImemAddr=PC, both stable until ImemAck.
  - IR <= ImemData in the cycle ImemReq & ImemAck.
  - Next state EXEC.
  - Waits indefinitely while ImemAck=0.
- EXEC:
  - Control outputs are decoded from IR and asserted for exactly this one cycle.
  - PC updates at the end of EXEC: PC+1, or the jump target.
  - Next state FETCH; HALT opcode goes to HALT instead.
- Throughput: 2 cycles per instruction with zero-wait ack.
- PC wraps from 2^PC_W-1 to 0 with no flag.
- Control outputs are functions of state and IR registers only; no combinational path from any input.
- All control outputs are 0 outside EXEC; A_Imm, AuOp and RegAddr also read 0.
- JZ samples AccZero during EXEC; the result of the previous LoadAcc is already visible at that point.
- HALT:
  - Halted=1, outputs quiet.
  - Start -> FETCH with PC=0; clears Halted; Illegal is retained.
- Start is ignored while in FETCH or EXEC.
- ImemAck outside FETCH is ignored.
- Reset (CLB=0, asynchronous):
  - State IDLE; PC, IR, Illegal, Halted cleared.
  - All outputs 0, including ImemReq dropping immediately mid-fetch.
  - Operation resumes only on a new Start.

Optional Feature:
- Macro ACC_SEQ_STEP_EN.
- When defined:
  - Adds input Step (1 bit) and state PAUSE.
  - After every EXEC the FSM enters PAUSE (Busy=0, outputs quiet).
  - Step pulse -> FETCH.
  - HALT still takes priority.
- When undefined: no Step port; EXEC -> FETCH directly.

Decomposition:
- Package acc_ctrl_pkg holds:
  - opcode constants;
  - state encoding;
  - instruction field positions;
  - a control-word typedef (LoadAcc, SelAcc1, SelAcc0, A_Imm, AuOp, RegAddr, RegWe, IsJmp, IsJz, IsHalt, IsIllegal).
- One sub-module: acc_instr_decoder, purely combinational, IR -> control word.
- The FSM and PC stay in the top level.

Test Plan:
- Program {0x13, 0x4 1, 0xF0}, zero-wait ack, Start → ADDI EXEC shows LoadAcc=1, Sel=00, A_Imm=3; STA EXEC shows RegWe=1, RegAddr=1; Halted=1 after 6 cycles.
- ImemAck delayed 3 cycles on the first fetch → ImemReq held high and ImemAddr=0 stable for 4 cycles; no control pulse before the ack.
- JZ 0x6 5 with AccZero=1 → next ImemAddr=5; repeated with AccZero=0 → next ImemAddr=PC+1.
- Opcode 0x9 → no LoadAcc or RegWe; Illegal=1 and stays 1 through a HALT/Start cycle; cleared only by CLB.
- CLB asserted mid-FETCH while ImemReq=1 → ImemReq=0 immediately, state IDLE; Start afterwards fetches from addr 0.
- PC_W=4, straight NOPs → ImemAddr sequence 14, 15, 0, 1.
